ram_io_responder: RTL
=====================

// Module: ram_io_responder
// PURPOSE
// - Byte-wide bus responder on the far side of the core's memory controller: serves its byte-serial ram_a/ram_dout/ram_wr cycles.
// - addr[17]=0 hits on-chip RAM; addr[17]=1 hits an IO window with TX/RX byte FIFOs toward the UART.
// - Read data is registered, valid the cycle after the address is presented; drives the controller's rdy to back-pressure TX pushes.
// PARAMETERS
// - RAM_AW      17  RAM byte-address width (2**RAM_AW bytes)
// - FIFO_AW     3   log2 FIFO depth (depth 8), both TX and RX
// PORTS
// - clk         in   1   clock, all state on posedge
// - rst         in   1   synchronous active-high reset
// - bus_addr    in   32  byte address from controller; bits [17:0] decoded, rest ignored
// - bus_wr      in   1   1 = write this cycle, 0 = read
// - bus_wdata   in   8   write byte
// - bus_rdata   out  8   read byte, registered
// - bus_rdy     out  1   combinational; 0 = stall controller (feeds its rdy)
// - tx_data     out  8   TX FIFO head byte
// - tx_valid    out  1   TX FIFO non-empty
// - tx_ready    in   1   UART accepts tx_data this cycle
// - rx_data     in   8   received byte
// - rx_valid    in   1   received byte offered
// - rx_ready    out  1   RX FIFO not full
// - halt        out  1   sticky halt request (RESP_HALT_EN only)
// BEHAVIOUR
// - Reset: bus_rdata=0, tx_valid=0, rx_ready=1, halt=0, both FIFOs empty; RAM contents NOT cleared. Reset mid-operation discards FIFO contents and any pending stall.
// - Every cycle is an access: no enable. Reads MUST be side-effect free (controller holds a stale address when idle).
// - RAM read: bus_rdata <= ram[addr[RAM_AW-1:0]] at posedge; 1-cycle latency. RAM write: ram[addr] <= bus_wdata at posedge when bus_wr & bus_rdy; bus_rdata unchanged on writes.
// - IO map (addr[17]=1, offset addr[3:0]):
//   0x0 read: RX head byte (peek, no pop); 0x00 if RX empty. 0x0 write: push bus_wdata into TX FIFO.
//   0x4 read: {6'b0, tx_full, rx_nonempty}. 0x4 write: see CONFIGURATION.
//   0x8 write: pop RX FIFO (data ignored; no-op if empty). 0x8 read: 0x00.
//   Other offsets: read 0x00, write ignored.
// - bus_rdy = ~(bus_wr & io & offset==0 & tx_full); while low, nothing is written and bus_rdata holds. Releases the cycle a TX pop frees an entry (same-cycle combinational from tx_ready & tx_valid NOT required; next cycle).
// - FIFO rules: push when valid&~full, pop when requested&~empty; push+pop same cycle when non-empty: count unchanged, both take effect; push+pop when full: pop only (full uses pre-cycle count). Pointers wrap mod 2**FIFO_AW; count is FIFO_AW+1 bits.
// - TX pop when tx_valid & tx_ready. RX push when rx_valid & rx_ready.
// CONFIGURATION
// - RESP_HALT_EN defined: write to IO 0x4 sets halt=1 (sticky until rst); halt also visible as status bit 7.
// - RESP_HALT_EN undefined: IO 0x4 writes ignored, halt tied 0, status bit 7 reads 0.
// STRUCTURE
// - Shared package/defines: IO base bit (17), offsets IO_DATA=4'h0, IO_STAT=4'h4, IO_RXPOP=4'h8, status bit positions.
// - One sub-module: byte_fifo (params FIFO_AW; push/pop/din/dout/full/empty), instantiated twice (TX, RX).
// - Top holds RAM array, address decode, bus_rdata register, stall logic, halt flag.
// TESTING
// - Write 0x00010<-0xAB, read 0x00010 -> bus_rdata=0xAB one cycle later; read 0x00011 unwritten does not disturb it.
// - tx_ready=0, write 9 bytes 0x01..0x09 to 0x30000 -> first 8 accepted, 9th holds bus_rdy=0; pulse tx_ready -> tx_data=0x01 popped, 9th accepted next cycle, order preserved.
// - rx_valid with 0x5A -> read 0x30000 repeatedly returns 0x5A (no pop), 0x30004 reads 0x01; write 0x30008 -> 0x30004 reads 0x00, 0x30000 reads 0x00.
// - RX full (8 bytes) + rx_valid + pop same cycle -> only pop, rx_ready rises next cycle; RX half-full push+pop same cycle -> count unchanged.
// - Fill TX with 3 bytes, assert rst one cycle -> tx_valid=0, bus_rdata=0, RAM byte written earlier still reads back.
// - RESP_HALT_EN: write 0x30004 -> halt=1 next cycle, stays 1; without macro halt stays 0.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/IO bus responder: IO window decode bit,
// IO register offsets, status bit positions and the read-source select.
package ram_io_responder_pkg;

  // Address bit that selects the IO window instead of on-chip RAM
  localparam int IO_BIT = 17;

  // IO register offsets (addr[3:0] inside the IO window)
  localparam logic [3:0] IO_DATA  = 4'h0;  // read: RX head peek, write: TX push
  localparam logic [3:0] IO_STAT  = 4'h4;  // read: status byte, write: halt request
  localparam logic [3:0] IO_RXPOP = 4'h8;  // write: pop RX head

  // Status byte bit positions
  localparam int STAT_RXNE   = 0;
  localparam int STAT_TXFULL = 1;
  localparam int STAT_HALT   = 7;

  // Which register feeds bus_rdata after a read
  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_IO  = 1'b1
  } rd_src_e;

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// byte_fifo: small synchronous byte FIFO with first-word-fall-through head.
// Push is ignored when full, pop ignored when empty; both decisions use the
// count at the start of the cycle, so push+pop on a full FIFO only pops.
module byte_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem_q [0:DEPTH-1];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests against pre-cycle occupancy and advance pointers/count
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + (FIFO_AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (FIFO_AW+1)'(1);
  end

  // Pointer and count registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide bus target behind the memory controller.
// addr[17]=0 reaches on-chip RAM, addr[17]=1 an IO window with TX/RX byte
// FIFOs toward the UART. Reads return one cycle later and have no side
// effects; writes to a full TX FIFO stall the controller via bus_rdy.
// Optional feature macro: RESP_HALT_EN (IO 0x4 write sets a sticky halt).
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt
);

  logic [7:0] ram_q [0:(1<<RAM_AW)-1];
  logic [7:0] ram_rdata_q;
  logic [7:0] io_rdata_q, io_rdata_d;
  rd_src_e    rd_src_q, rd_src_d;

  logic       is_io;
  logic [3:0] io_off;
  logic       wr_ok;
  logic       ram_we, tx_push, rx_pop, halt_set;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic [7:0] status;
  logic       halt_flag;
  logic       unused_addr_hi;

  assign is_io          = bus_addr[IO_BIT];
  assign io_off         = bus_addr[3:0];
  assign unused_addr_hi = ^bus_addr[31:IO_BIT+1];

  // Only a TX push into a full FIFO stalls; tx_full is registered, so the
  // stall releases the cycle after a TX pop frees an entry.
  assign bus_rdy = ~(bus_wr & is_io & (io_off == IO_DATA) & tx_full);
  assign wr_ok   = bus_wr & bus_rdy;

  // Decode write side effects
  always_comb begin
    ram_we   = wr_ok & ~is_io;
    tx_push  = wr_ok & is_io & (io_off == IO_DATA);
    rx_pop   = wr_ok & is_io & (io_off == IO_RXPOP);
    halt_set = wr_ok & is_io & (io_off == IO_STAT);
  end

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (bus_wdata),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

`ifdef RESP_HALT_EN
  logic halt_q, halt_d;

  // Sticky halt request, cleared only by reset
  always_comb begin
    halt_d = halt_q | halt_set;
  end

  // Halt flag register
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end

  assign halt_flag = halt_q;
`else
  logic unused_halt_set;
  assign unused_halt_set = halt_set;
  assign halt_flag       = 1'b0;
`endif

  assign halt = halt_flag;

  // Build the status byte from live FIFO flags
  always_comb begin
    status              = '0;
    status[STAT_RXNE]   = ~rx_empty;
    status[STAT_TXFULL] = tx_full;
    status[STAT_HALT]   = halt_flag;
  end

  // IO read mux; on writes the previous read data and source are held
  always_comb begin
    io_rdata_d = io_rdata_q;
    rd_src_d   = rd_src_q;
    if (!bus_wr) begin
      rd_src_d = is_io ? SRC_IO : SRC_RAM;
      unique case (io_off)
        IO_DATA: io_rdata_d = rx_empty ? 8'h00 : rx_head;
        IO_STAT: io_rdata_d = status;
        default: io_rdata_d = 8'h00;
      endcase
    end
  end

  // IO read register and source select; reset selects IO with data 0x00
  always_ff @(posedge clk) begin
    if (rst) begin
      io_rdata_q <= 8'h00;
      rd_src_q   <= SRC_IO;
    end else begin
      io_rdata_q <= io_rdata_d;
      rd_src_q   <= rd_src_d;
    end
  end

  // RAM array with registered read port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[bus_addr[RAM_AW-1:0]] <= bus_wdata;
    if (!bus_wr) ram_rdata_q <= ram_q[bus_addr[RAM_AW-1:0]];
  end

  assign bus_rdata = (rd_src_q == SRC_IO) ? io_rdata_q : ram_rdata_q;

endmodule
